trap_unit: RTL and testbench
============================

Name: trap_unit

Overview:
- Machine-mode trap/interrupt responder that drives the trap side of the CPU controller's protocol: trap_valid_o, interrupt_taken_o, mret_o and wfi_o.
- Holds mstatus.MIE/MPIE, mie, mtvec, mepc and mcause, and produces the redirect PC.
- Sits beside the CSR file at the commit (WB) boundary.
- Resolves exceptions, external and timer interrupts, MRET and WFI wake-up against each retiring instruction.

Parameters:
XLEN, 32, data/PC width
MTVEC_RESET, 32'h0000_0000, reset value of mtvec
SYNC_STAGES, 2, synchronizer depth for ext_irq_i (min 2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
commit_valid_i  in  1  an instruction retires this cycle
commit_pc_i  in  XLEN  PC of retiring instruction
commit_npc_i  in  XLEN  architectural next PC of retiring instruction
exception_i  in  1  retiring instruction faulted
exc_cause_i  in  4  exception code
mret_inst_i  in  1  retiring instruction is MRET
wfi_inst_i  in  1  retiring instruction is WFI
ext_irq_i  in  1  external interrupt level, asynchronous
timer_irq_i  in  1  timer interrupt level, clk_i domain
csr_we_i  in  1  CSR write by retiring instruction
csr_addr_i  in  12  CSR address
csr_wdata_i  in  XLEN  CSR write data
csr_rdata_o  out  XLEN  CSR read data, combinational on csr_addr_i
trap_valid_o  out  1  trap entry this cycle
interrupt_taken_o  out  1  WFI exit / interrupt accepted
mret_o  out  1  MRET executes this cycle
wfi_o  out  1  WFI enters wait this cycle
redirect_pc_o  out  XLEN  fetch target when trap_valid_o or mret_o
mstatus_mie_o  out  1  global interrupt enable

Behaviour:
- Reset, asynchronous on rst_ni low:
  - mstatus.MIE = 0, MPIE = 0, mie = 0, mepc = 0, mcause = 0, mtvec = MTVEC_RESET.
  - Synchronizer flops cleared; FSM = RUN.
  - All pulse outputs 0, redirect_pc_o = 0.
  - Reset mid-trap or mid-wait discards all state.
- Interrupt sources:
  - meip = ext_irq_i after SYNC_STAGES flops; mtip = timer_irq_i directly.
  - mip reads {.., bit11 = meip, bit7 = mtip}; mip writes are ignored.
  - pend = (mie[11] & meip) | (mie[7] & mtip).
  - take_irq = pend & MIE.
- CSR map, active only when csr_we_i & commit_valid_i and no trap this cycle:
  - 0x300 mstatus: only bits 3 (MIE) and 7 (MPIE) writable; others read 0.
  - 0x304 mie: bits 11 and 7 writable.
  - 0x305 mtvec: bit1 reads 0; bit0 = vectored mode.
  - 0x341 mepc: bits[1:0] forced 0.
  - 0x342 mcause.
  - 0x344 mip: read-only.
  - Unmapped addresses read 0 and writes are dropped.
- Outputs are combinational from current inputs and state; state updates on the next clk_i edge.
- FSM state RUN, evaluated when commit_valid_i, priority highest first:
  1. exception_i → trap_valid_o. mepc ← commit_pc_i; mcause ← {0, exc_cause_i}; redirect = mtvec base.
  2. take_irq → trap_valid_o and interrupt_taken_o. mepc ← commit_npc_i; mcause ← {1, 11 (ext) or 7 (timer)}, ext wins over timer. Redirect = base, or base + 4·code if vectored.
  3. mret_inst_i → mret_o. redirect = mepc; MIE ← MPIE; MPIE ← 1.
  4. wfi_inst_i with pend = 0 → wfi_o; go to WAIT. With pend = 1, WFI retires as a NOP.
  - Any trap entry also sets MPIE ← MIE and MIE ← 0.
- Interrupts are never taken while commit_valid_i = 0 in RUN; they stay pending.
- FSM state WAIT, commit_valid_i ignored:
  - pend = 1 and MIE = 1 → trap_valid_o and interrupt_taken_o; mepc ← saved WFI commit_npc; mcause as above; go to RUN.
  - pend = 1 and MIE = 0 → interrupt_taken_o only, no redirect; go to RUN.
  - pend = 0 → stay in WAIT; all outputs 0.
- Simultaneous events:
  - A trap and a CSR write on the same instruction: the trap wins and the write is dropped.
  - An exception together with a pending interrupt: the exception wins and the interrupt stays pending for the next commit.
  - An MRET that faults: exception path only.
- Outputs are mutually consistent: mret_o and trap_valid_o are never both 1; wfi_o is never 1 together with either.

Test Plan:
- Reset, then read 0x305 → MTVEC_RESET; 0x300 → 0; all outputs 0.
- mtvec = 0x100, commit pc 0x40 with exception_i, cause 2 → same-cycle trap_valid_o = 1, redirect 0x100; next cycle mepc = 0x40, mcause = 2, MIE = 0, MPIE = old MIE.
- MIE = 1, mie[7] = 1, timer_irq_i = 1, commit pc 0x80 / npc 0x84, mtvec = 0x101 → trap_valid_o and interrupt_taken_o, redirect 0x11C, mepc 0x84, mcause 0x8000_0007.
- ext_irq_i and timer both pending with mie = 0x880 → response exactly SYNC_STAGES cycles after ext rises; mcause 0x8000_000B.
- MRET with mepc = 0x200, MPIE = 1 → mret_o, redirect 0x200; then MIE = 1, MPIE = 1.
- WFI with pend = 0 → wfi_o, WAIT held for 10 cycles while commit inputs toggle; timer rises with MIE = 0 → interrupt_taken_o only, FSM back to RUN.
- Exception, CSR write to mie, and pending interrupt on the same commit → exception trap only; mie unchanged.

Source files
------------

// File: rtl/trap_unit.sv
// -----------------------------------------------------------------------------
// trap_unit
//   Machine-mode trap and interrupt responder at the commit (WB) boundary.
//   Holds mstatus.MIE/MPIE, mie, mtvec, mepc and mcause. For each retiring
//   instruction it resolves exceptions, external/timer interrupts, MRET and
//   WFI, and produces the fetch redirect PC.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   commit_valid_i        an instruction retires this cycle
//   commit_pc_i/npc_i     PC and architectural next PC of that instruction
//   exception_i/exc_cause_i  the instruction faulted, with its exception code
//   mret_inst_i           retiring instruction is MRET
//   wfi_inst_i            retiring instruction is WFI
//   ext_irq_i             external interrupt level (asynchronous)
//   timer_irq_i           timer interrupt level (clk_i domain)
//   csr_we_i/addr_i/wdata_i  CSR write by the retiring instruction
//   csr_rdata_o           CSR read data, combinational on csr_addr_i
//   trap_valid_o          trap entry this cycle
//   interrupt_taken_o     interrupt accepted or WFI exit
//   mret_o                MRET executes this cycle
//   wfi_o                 WFI enters wait this cycle
//   redirect_pc_o         fetch target when trap_valid_o or mret_o
//   mstatus_mie_o         global interrupt enable
// -----------------------------------------------------------------------------
module trap_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter int unsigned     SYNC_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            commit_valid_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic [XLEN-1:0] commit_npc_i,
  input  logic            exception_i,
  input  logic [3:0]      exc_cause_i,
  input  logic            mret_inst_i,
  input  logic            wfi_inst_i,
  input  logic            ext_irq_i,
  input  logic            timer_irq_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            trap_valid_o,
  output logic            interrupt_taken_o,
  output logic            mret_o,
  output logic            wfi_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            mstatus_mie_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  // mtvec bit 1 is hard-wired to zero, including in the reset value.
  localparam logic [XLEN-1:0] MTVEC_INIT = MTVEC_RESET & ~XLEN'(2);

  typedef enum logic {
    ST_RUN,
    ST_WAIT
  } state_e;

  state_e state_q, state_d;

  // Architectural state
  logic            mstatus_mie_q;
  logic            mstatus_mpie_q;
  logic            mie_meie_q;     // mie[11]
  logic            mie_mtie_q;     // mie[7]
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] wfi_npc_q;      // return address saved when WFI enters wait

  logic [SYNC_STAGES-1:0] sync_q;

  // Interrupt resolution
  logic            meip, mtip, ext_pend, pend, take_irq;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] mtvec_base, irq_target, irq_cause;

  // Per-cycle decisions from the FSM
  logic            csr_wr_en;
  logic [XLEN-1:0] trap_epc, trap_cause;

  assign meip     = sync_q[SYNC_STAGES-1];
  assign mtip     = timer_irq_i;
  assign ext_pend = mie_meie_q & meip;
  assign pend     = ext_pend | (mie_mtie_q & mtip);
  assign take_irq = pend & mstatus_mie_q;

  // External outranks timer when both are pending.
  assign irq_code   = ext_pend ? 4'd11 : 4'd7;
  assign irq_cause  = {1'b1, {(XLEN-5){1'b0}}, irq_code};
  assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};
  assign irq_target = mtvec_q[0] ? mtvec_base + {{(XLEN-6){1'b0}}, irq_code, 2'b00}
                                 : mtvec_base;

  assign mstatus_mie_o = mstatus_mie_q;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d           = state_q;
    trap_valid_o      = 1'b0;
    interrupt_taken_o = 1'b0;
    mret_o            = 1'b0;
    wfi_o             = 1'b0;
    redirect_pc_o     = '0;
    trap_epc          = '0;
    trap_cause        = '0;
    csr_wr_en         = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (commit_valid_i) begin
          if (exception_i) begin
            trap_valid_o  = 1'b1;
            redirect_pc_o = mtvec_base;
            trap_epc      = commit_pc_i;
            trap_cause    = {{(XLEN-4){1'b0}}, exc_cause_i};
          end else if (take_irq) begin
            // The retiring instruction completes; resume after it.
            trap_valid_o      = 1'b1;
            interrupt_taken_o = 1'b1;
            redirect_pc_o     = irq_target;
            trap_epc          = commit_npc_i;
            trap_cause        = irq_cause;
          end else if (mret_inst_i) begin
            mret_o        = 1'b1;
            redirect_pc_o = mepc_q;
          end else if (wfi_inst_i && !pend) begin
            // With an interrupt already pending (but masked) WFI is a NOP.
            wfi_o   = 1'b1;
            state_d = ST_WAIT;
          end
          csr_wr_en = csr_we_i & ~trap_valid_o;
        end
      end

      ST_WAIT: begin
        if (pend) begin
          interrupt_taken_o = 1'b1;
          state_d           = ST_RUN;
          if (mstatus_mie_q) begin
            trap_valid_o  = 1'b1;
            redirect_pc_o = irq_target;
            trap_epc      = wfi_npc_q;
            trap_cause    = irq_cause;
          end
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ext_irq_i synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], ext_irq_i};
  end

  // ---------------------------------------------------------------------------
  // CSR state. A CSR write is applied first; trap entry and MRET are applied
  // after it so their mstatus effects take precedence on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mtvec_q        <= MTVEC_INIT;
      mepc_q         <= '0;
      mcause_q       <= '0;
      wfi_npc_q      <= '0;
    end else begin
      if (csr_wr_en) begin
        unique case (csr_addr_i)
          ADDR_MSTATUS: begin
            mstatus_mie_q  <= csr_wdata_i[3];
            mstatus_mpie_q <= csr_wdata_i[7];
          end
          ADDR_MIE: begin
            mie_meie_q <= csr_wdata_i[11];
            mie_mtie_q <= csr_wdata_i[7];
          end
          ADDR_MTVEC:  mtvec_q  <= {csr_wdata_i[XLEN-1:2], 1'b0, csr_wdata_i[0]};
          ADDR_MEPC:   mepc_q   <= {csr_wdata_i[XLEN-1:2], 2'b00};
          ADDR_MCAUSE: mcause_q <= csr_wdata_i;
          default: ;   // mip is read-only; unmapped writes are dropped
        endcase
      end

      if (trap_valid_o) begin
        mepc_q         <= trap_epc;
        mcause_q       <= trap_cause;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (mret_o) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end

      if (wfi_o) wfi_npc_q <= commit_npc_i;
    end
  end

  // ---------------------------------------------------------------------------
  // CSR read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    csr_rdata_o = '0;
    unique case (csr_addr_i)
      ADDR_MSTATUS: begin
        csr_rdata_o[3] = mstatus_mie_q;
        csr_rdata_o[7] = mstatus_mpie_q;
      end
      ADDR_MIE: begin
        csr_rdata_o[11] = mie_meie_q;
        csr_rdata_o[7]  = mie_mtie_q;
      end
      ADDR_MTVEC:  csr_rdata_o = mtvec_q;
      ADDR_MEPC:   csr_rdata_o = mepc_q;
      ADDR_MCAUSE: csr_rdata_o = mcause_q;
      ADDR_MIP: begin
        csr_rdata_o[11] = meip;
        csr_rdata_o[7]  = mtip;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_unit.sv
// -----------------------------------------------------------------------------
// tb_trap_unit
//   Directed self-checking bench for trap_unit. Inputs change 1 ns after the
//   rising edge; combinational outputs are sampled 1 ns after that.
// -----------------------------------------------------------------------------
module tb_trap_unit;

  localparam int unsigned XLEN        = 32;
  localparam logic [31:0] MTVEC_RST   = 32'h0000_0080;
  localparam int unsigned SYNC_STAGES = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            commit_valid_i;
  logic [XLEN-1:0] commit_pc_i;
  logic [XLEN-1:0] commit_npc_i;
  logic            exception_i;
  logic [3:0]      exc_cause_i;
  logic            mret_inst_i;
  logic            wfi_inst_i;
  logic            ext_irq_i;
  logic            timer_irq_i;
  logic            csr_we_i;
  logic [11:0]     csr_addr_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic [XLEN-1:0] csr_rdata_o;
  logic            trap_valid_o;
  logic            interrupt_taken_o;
  logic            mret_o;
  logic            wfi_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            mstatus_mie_o;

  logic [3:0]  outs;   // {trap_valid, interrupt_taken, mret, wfi}
  logic [31:0] rd;
  int          n_checks = 0;
  int          n_fail   = 0;

  assign outs = {trap_valid_o, interrupt_taken_o, mret_o, wfi_o};

  trap_unit #(
    .XLEN        (XLEN),
    .MTVEC_RESET (MTVEC_RST),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .commit_valid_i    (commit_valid_i),
    .commit_pc_i       (commit_pc_i),
    .commit_npc_i      (commit_npc_i),
    .exception_i       (exception_i),
    .exc_cause_i       (exc_cause_i),
    .mret_inst_i       (mret_inst_i),
    .wfi_inst_i        (wfi_inst_i),
    .ext_irq_i         (ext_irq_i),
    .timer_irq_i       (timer_irq_i),
    .csr_we_i          (csr_we_i),
    .csr_addr_i        (csr_addr_i),
    .csr_wdata_i       (csr_wdata_i),
    .csr_rdata_o       (csr_rdata_o),
    .trap_valid_o      (trap_valid_o),
    .interrupt_taken_o (interrupt_taken_o),
    .mret_o            (mret_o),
    .wfi_o             (wfi_o),
    .redirect_pc_o     (redirect_pc_o),
    .mstatus_mie_o     (mstatus_mie_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_commit();
    commit_valid_i = 1'b0;
    commit_pc_i    = '0;
    commit_npc_i   = '0;
    exception_i    = 1'b0;
    exc_cause_i    = '0;
    mret_inst_i    = 1'b0;
    wfi_inst_i     = 1'b0;
    csr_we_i       = 1'b0;
    csr_addr_i     = '0;
    csr_wdata_i    = '0;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    commit_valid_i = 1'b1;
    csr_we_i       = 1'b1;
    csr_addr_i     = addr;
    csr_wdata_i    = data;
    step();
    clear_commit();
  endtask

  task automatic csr_read(input logic [11:0] addr, output logic [31:0] data);
    csr_addr_i = addr;
    #1;
    data = csr_rdata_o;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] npc);
    commit_valid_i = 1'b1;
    commit_pc_i    = pc;
    commit_npc_i   = npc;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_ni      = 1'b0;
    ext_irq_i   = 1'b0;
    timer_irq_i = 1'b0;
    clear_commit();
    #3;
    n_checks++; if (outs !== 4'b0000) begin n_fail++; $display("FAIL reset_outs: got %b want 0000", outs); end
    n_checks++; if (redirect_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_redirect: got %h want 0", redirect_pc_o); end
    n_checks++; if (mstatus_mie_o !== 1'b0) begin n_fail++; $display("FAIL reset_mie_o: got %b want 0", mstatus_mie_o); end
    #19 rst_ni = 1'b1;
    step();
    csr_read(12'h305, rd);
    n_checks++; if (rd !== MTVEC_RST) begin n_fail++; $display("FAIL reset_mtvec: got %h want %h", rd, MTVEC_RST); end
    csr_read(12'h300, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_mstatus: got %h want 0", rd); end
    csr_read(12'h304, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_mie: got %h want 0", rd); end
    step();
    csr_read(12'h341, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_mepc: got %h want 0", rd); end
    csr_read(12'h342, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_mcause: got %h want 0", rd); end
    step();
  endtask

  task automatic test_csr_map();
    csr_write(12'h300, 32'hFFFF_FFFF);
    csr_read(12'h300, rd);
    n_checks++; if (rd !== 32'h0000_0088) begin n_fail++; $display("FAIL csr_mstatus_mask: got %h want 00000088", rd); end
    csr_write(12'h304, 32'hFFFF_FFFF);
    csr_read(12'h304, rd);
    n_checks++; if (rd !== 32'h0000_0880) begin n_fail++; $display("FAIL csr_mie_mask: got %h want 00000880", rd); end
    csr_write(12'h305, 32'hFFFF_FFFF);
    csr_read(12'h305, rd);
    n_checks++; if (rd !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL csr_mtvec_mask: got %h want fffffffd", rd); end
    csr_write(12'h341, 32'h0000_0123);
    csr_read(12'h341, rd);
    n_checks++; if (rd !== 32'h0000_0120) begin n_fail++; $display("FAIL csr_mepc_align: got %h want 00000120", rd); end
    csr_write(12'h342, 32'h8000_DEAD);
    csr_read(12'h342, rd);
    n_checks++; if (rd !== 32'h8000_DEAD) begin n_fail++; $display("FAIL csr_mcause: got %h want 8000dead", rd); end
    csr_write(12'h344, 32'hFFFF_FFFF);
    csr_read(12'h344, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL csr_mip_ro: got %h want 0", rd); end
    csr_write(12'h7C0, 32'hFFFF_FFFF);
    csr_read(12'h7C0, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL csr_unmapped: got %h want 0", rd); end
    csr_write(12'h300, 32'h0);
    csr_write(12'h304, 32'h0);
  endtask

  task automatic test_exception();
    csr_write(12'h305, 32'h0000_0100);
    csr_write(12'h300, 32'h0000_0008);
    commit(32'h40, 32'h44);
    exception_i = 1'b1;
    exc_cause_i = 4'd2;
    #1;
    n_checks++; if (outs !== 4'b1000) begin n_fail++; $display("FAIL exc_outs: got %b want 1000", outs); end
    n_checks++; if (redirect_pc_o !== 32'h100) begin n_fail++; $display("FAIL exc_redirect: got %h want 00000100", redirect_pc_o); end
    step();
    clear_commit();
    csr_read(12'h341, rd);
    n_checks++; if (rd !== 32'h40) begin n_fail++; $display("FAIL exc_mepc: got %h want 00000040", rd); end
    csr_read(12'h342, rd);
    n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL exc_mcause: got %h want 00000002", rd); end
    csr_read(12'h300, rd);
    n_checks++; if (rd !== 32'h80) begin n_fail++; $display("FAIL exc_mstatus: got %h want 00000080", rd); end
    step();
  endtask

  task automatic test_timer_irq();
    csr_write(12'h305, 32'h0000_0101);
    csr_write(12'h304, 32'h0000_0080);
    csr_write(12'h300, 32'h0000_0008);
    timer_irq_i = 1'b1;
    #1;
    n_checks++; if (outs !== 4'b0000) begin n_fail++; $display("FAIL tmr_no_commit: got %b want 0000", outs); end
    step();
    commit(32'h80, 32'h84);
    #1;
    n_checks++; if (outs !== 4'b1100) begin n_fail++; $display("FAIL tmr_outs: got %b want 1100", outs); end
    n_checks++; if (redirect_pc_o !== 32'h11C) begin n_fail++; $display("FAIL tmr_redirect: got %h want 0000011c", redirect_pc_o); end
    step();
    clear_commit();
    timer_irq_i = 1'b0;
    csr_read(12'h341, rd);
    n_checks++; if (rd !== 32'h84) begin n_fail++; $display("FAIL tmr_mepc: got %h want 00000084", rd); end
    csr_read(12'h342, rd);
    n_checks++; if (rd !== 32'h8000_0007) begin n_fail++; $display("FAIL tmr_mcause: got %h want 80000007", rd); end
    csr_read(12'h300, rd);
    n_checks++; if (rd !== 32'h80) begin n_fail++; $display("FAIL tmr_mstatus: got %h want 00000080", rd); end
    step();
  endtask

  task automatic test_ext_sync();
    csr_write(12'h305, 32'h0000_0100);
    csr_write(12'h304, 32'h0000_0880);
    csr_write(12'h300, 32'h0000_0008);
    timer_irq_i = 1'b1;
    ext_irq_i   = 1'b1;
    step();
    csr_read(12'h344, rd);
    n_checks++; if (rd !== 32'h080) begin n_fail++; $display("FAIL ext_sync_1: got %h want 00000080", rd); end
    step();
    csr_read(12'h344, rd);
    n_checks++; if (rd !== 32'h880) begin n_fail++; $display("FAIL ext_sync_2: got %h want 00000880", rd); end
    commit(32'h90, 32'h94);
    #1;
    n_checks++; if (outs !== 4'b1100) begin n_fail++; $display("FAIL ext_outs: got %b want 1100", outs); end
    n_checks++; if (redirect_pc_o !== 32'h100) begin n_fail++; $display("FAIL ext_redirect: got %h want 00000100", redirect_pc_o); end
    step();
    clear_commit();
    ext_irq_i   = 1'b0;
    timer_irq_i = 1'b0;
    csr_read(12'h342, rd);
    n_checks++; if (rd !== 32'h8000_000B) begin n_fail++; $display("FAIL ext_mcause: got %h want 8000000b", rd); end
    csr_read(12'h341, rd);
    n_checks++; if (rd !== 32'h94) begin n_fail++; $display("FAIL ext_mepc: got %h want 00000094", rd); end
    step();
    step();
    step();
  endtask

  task automatic test_mret();
    csr_write(12'h341, 32'h0000_0200);
    commit(32'h1F0, 32'h1F4);
    mret_inst_i = 1'b1;
    #1;
    n_checks++; if (outs !== 4'b0010) begin n_fail++; $display("FAIL mret_outs: got %b want 0010", outs); end
    n_checks++; if (redirect_pc_o !== 32'h200) begin n_fail++; $display("FAIL mret_redirect: got %h want 00000200", redirect_pc_o); end
    step();
    clear_commit();
    csr_read(12'h300, rd);
    n_checks++; if (rd !== 32'h88) begin n_fail++; $display("FAIL mret_mstatus: got %h want 00000088", rd); end
    n_checks++; if (mstatus_mie_o !== 1'b1) begin n_fail++; $display("FAIL mret_mie_o: got %b want 1", mstatus_mie_o); end
    step();
  endtask

  task automatic test_wfi_wake();
    csr_write(12'h300, 32'h0);
    csr_write(12'h304, 32'h0000_0080);
    commit(32'h300, 32'h304);
    wfi_inst_i = 1'b1;
    #1;
    n_checks++; if (outs !== 4'b0001) begin n_fail++; $display("FAIL wfi_enter: got %b want 0001", outs); end
    step();
    clear_commit();
    for (int i = 0; i < 10; i++) begin
      commit_valid_i = i[0];
      exception_i    = i[1];
      mret_inst_i    = i[2];
      wfi_inst_i     = 1'b1;
      csr_we_i       = 1'b1;
      csr_addr_i     = 12'h300;
      csr_wdata_i    = 32'h8;
      #1;
      n_checks++; if (outs !== 4'b0000 || redirect_pc_o !== 32'h0) begin n_fail++; $display("FAIL wfi_hold[%0d]: got %b/%h want 0000/0", i, outs, redirect_pc_o); end
      step();
    end
    clear_commit();
    csr_read(12'h300, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wfi_csr_ignored: got %h want 0", rd); end
    timer_irq_i = 1'b1;
    #1;
    n_checks++; if (outs !== 4'b0100) begin n_fail++; $display("FAIL wfi_wake_outs: got %b want 0100", outs); end
    n_checks++; if (redirect_pc_o !== 32'h0) begin n_fail++; $display("FAIL wfi_wake_redirect: got %h want 0", redirect_pc_o); end
    step();
    #1;
    n_checks++; if (outs !== 4'b0000) begin n_fail++; $display("FAIL wfi_back_run: got %b want 0000", outs); end
    commit(32'h308, 32'h30C);
    wfi_inst_i = 1'b1;
    #1;
    n_checks++; if (outs !== 4'b0000) begin n_fail++; $display("FAIL wfi_nop_pending: got %b want 0000", outs); end
    step();
    clear_commit();
    timer_irq_i = 1'b0;
    csr_read(12'h341, rd);
    n_checks++; if (rd !== 32'h200) begin n_fail++; $display("FAIL wfi_mepc_kept: got %h want 00000200", rd); end
    step();
  endtask

  task automatic test_wfi_trap();
    csr_write(12'h300, 32'h8);
    commit(32'h400, 32'h404);
    wfi_inst_i = 1'b1;
    #1;
    n_checks++; if (outs !== 4'b0001) begin n_fail++; $display("FAIL wfit_enter: got %b want 0001", outs); end
    step();
    clear_commit();
    #1;
    n_checks++; if (outs !== 4'b0000) begin n_fail++; $display("FAIL wfit_wait: got %b want 0000", outs); end
    step();
    timer_irq_i = 1'b1;
    #1;
    n_checks++; if (outs !== 4'b1100) begin n_fail++; $display("FAIL wfit_outs: got %b want 1100", outs); end
    n_checks++; if (redirect_pc_o !== 32'h100) begin n_fail++; $display("FAIL wfit_redirect: got %h want 00000100", redirect_pc_o); end
    step();
    timer_irq_i = 1'b0;
    csr_read(12'h341, rd);
    n_checks++; if (rd !== 32'h404) begin n_fail++; $display("FAIL wfit_mepc: got %h want 00000404", rd); end
    csr_read(12'h342, rd);
    n_checks++; if (rd !== 32'h8000_0007) begin n_fail++; $display("FAIL wfit_mcause: got %h want 80000007", rd); end
    csr_read(12'h300, rd);
    n_checks++; if (rd !== 32'h80) begin n_fail++; $display("FAIL wfit_mstatus: got %h want 00000080", rd); end
    step();
  endtask

  task automatic test_simultaneous();
    csr_write(12'h300, 32'h8);
    timer_irq_i = 1'b1;
    commit(32'h500, 32'h504);
    exception_i = 1'b1;
    exc_cause_i = 4'd5;
    csr_we_i    = 1'b1;
    csr_addr_i  = 12'h304;
    csr_wdata_i = 32'h880;
    #1;
    n_checks++; if (outs !== 4'b1000) begin n_fail++; $display("FAIL sim_outs: got %b want 1000", outs); end
    n_checks++; if (redirect_pc_o !== 32'h100) begin n_fail++; $display("FAIL sim_redirect: got %h want 00000100", redirect_pc_o); end
    step();
    clear_commit();
    csr_read(12'h304, rd);
    n_checks++; if (rd !== 32'h80) begin n_fail++; $display("FAIL sim_mie_kept: got %h want 00000080", rd); end
    csr_read(12'h342, rd);
    n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL sim_mcause: got %h want 00000005", rd); end
    csr_read(12'h341, rd);
    n_checks++; if (rd !== 32'h500) begin n_fail++; $display("FAIL sim_mepc: got %h want 00000500", rd); end
    step();
    // Interrupt is still pending; re-enable and it is taken on the next commit.
    csr_write(12'h300, 32'h8);
    commit(32'h540, 32'h544);
    #1;
    n_checks++; if (outs !== 4'b1100) begin n_fail++; $display("FAIL sim_irq_next: got %b want 1100", outs); end
    step();
    clear_commit();
    timer_irq_i = 1'b0;
    csr_read(12'h341, rd);
    n_checks++; if (rd !== 32'h544) begin n_fail++; $display("FAIL sim_irq_mepc: got %h want 00000544", rd); end
    step();
    // Faulting MRET: exception only, mstatus follows trap entry.
    commit(32'h600, 32'h604);
    mret_inst_i = 1'b1;
    exception_i = 1'b1;
    exc_cause_i = 4'd3;
    #1;
    n_checks++; if (outs !== 4'b1000) begin n_fail++; $display("FAIL mret_fault_outs: got %b want 1000", outs); end
    step();
    clear_commit();
    csr_read(12'h300, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mret_fault_mstatus: got %h want 0", rd); end
    csr_read(12'h342, rd);
    n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL mret_fault_mcause: got %h want 00000003", rd); end
    step();
  endtask

  task automatic test_reset_mid_wait();
    csr_write(12'h305, 32'h0000_0300);
    commit(32'h700, 32'h704);
    wfi_inst_i = 1'b1;
    step();
    clear_commit();
    rst_ni = 1'b0;
    #2;
    csr_read(12'h305, rd);
    n_checks++; if (rd !== MTVEC_RST) begin n_fail++; $display("FAIL rst_wait_mtvec: got %h want %h", rd, MTVEC_RST); end
    rst_ni = 1'b1;
    step();
    commit(32'h710, 32'h714);
    wfi_inst_i = 1'b1;
    #1;
    n_checks++; if (outs !== 4'b0001) begin n_fail++; $display("FAIL rst_wait_run: got %b want 0001", outs); end
    step();
    clear_commit();
  endtask

  initial begin
    test_reset();
    test_csr_map();
    test_exception();
    test_timer_irq();
    test_ext_sync();
    test_mret();
    test_wfi_wake();
    test_wfi_trap();
    test_simultaneous();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
